board_store: RTL and testbench
==============================

# board_store

Holds the 10×20 occupancy grid for the playfield, downstream of `gamelogic`. It accepts single-cell writes from the piece-lock path and serves the single-cell reads used by the collision check. It also exposes a whole-row read port for the renderer. On request, it runs a sequential line-clear pass that removes every full row, shifts the rows above down, and reports how many lines were cleared.

## Interface
Parameters:
- `COLS`, 10: board width in cells; row vector width.
- `ROWS`, 20: board height in cells.

Ports:
- `CLOCK_50`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `board_rx`  in  4: read column address.
- `board_ry`  in  5: read row address.
- `board_rdata`  out  1: combinational occupancy of (`board_rx`, `board_ry`).
- `board_we`  in  1: single-cycle cell write enable.
- `board_wx`  in  4: write column.
- `board_wy`  in  5: write row.
- `board_wdata`  in  1: value written to the cell.
- `vga_ry`  in  5: renderer row address.
- `vga_row`  out  10: combinational contents of row `vga_ry`; bit x is column x.
- `clear_start`  in  1: one-cycle pulse requesting a line-clear pass.
- `clear_busy`  out  1: high while a pass is in progress.
- `clear_done`  out  1: one-cycle pulse at the end of a pass.
- `lines_cleared`  out  3: number of full rows removed by the last pass, 0–4.
- `total_lines`  out  10: cumulative lines cleared (see Configuration).

## Operation
- Storage: `ROWS` registers of `COLS` bits each. Row 0 is the top row; row 19 is the bottom.
- Read port:
  - `board_rdata` = cell value when `board_rx` ≤ 9 and `board_ry` ≤ 19.
  - Otherwise `board_rdata` = 1. Out-of-range cells read as wall, so the collision check needs no separate bounds test.
  - `vga_row` = row contents; 0 when `vga_ry` > 19.
- Write port:
  - When `board_we` = 1 in IDLE with in-range coordinates, the cell takes `board_wdata` at the next edge.
  - Out-of-range writes are dropped.
  - Writes arriving while `clear_busy` = 1 are dropped.
- FSM states: IDLE, SCAN, FILL, DONE.
  - IDLE: `clear_start` = 1 → SCAN. Set src = 19, dst = 19, count = 0.
  - SCAN, one source row per cycle:
    - If row[src] is all ones, count++.
    - Otherwise row[dst] ← row[src] and dst--.
    - src-- in both cases.
    - After processing src = 0: go to FILL if count ≠ 0, else DONE.
  - FILL: row[dst] ← 0, dst--. After row 0 is written → DONE. FILL lasts exactly `count` cycles.
  - DONE: `lines_cleared` ← count, `clear_done` = 1 → IDLE.
- Full-row test: AND-reduce of all 10 bits of row[src].
- src and dst are 5-bit. Termination uses an explicit last-row flag, not underflow wrap.
- `clear_start` outside IDLE is ignored.
- If `board_we` and `clear_start` arrive in the same IDLE cycle, the write commits first and the pass sees it.
- Reset mid-pass: all rows clear to 0, FSM returns to IDLE, no `clear_done` pulse.

## Timing
- Reset values:
  - all cells 0
  - `clear_busy` 0, `clear_done` 0, `lines_cleared` 0, `total_lines` 0
  - `board_rdata` and `vga_row` follow the reset contents combinationally.
- Reads have zero latency. A write is visible on `board_rdata` the cycle after `board_we`.
- With `clear_start` sampled at edge k:
  - `clear_busy` goes high after edge k and stays high through SCAN (20 cycles), FILL (N cycles) and DONE (1 cycle).
  - `clear_done` is asserted after edge k+21+N.
  - `clear_busy` falls after edge k+22+N.
- `lines_cleared` updates with `clear_done` and holds until the next pass's DONE.
- Mid-pass reads return partially shifted data. The consumer must not read while `clear_busy` = 1.

## Configuration
- `BOARD_STATS_EN` defined:
  - `total_lines` accumulates `lines_cleared` in the DONE cycle.
  - It saturates at 1023 and clears only on reset.
- `BOARD_STATS_EN` undefined: no accumulator register; `total_lines` is tied to 0.

## Test plan
- Reset, then sweep reads → every in-range cell 0. Read (10,0) → 1; (0,20) → 1. `vga_ry` = 25 → `vga_row` = 0.
- Write (3,7)=1, read the next cycle → 1. Write (3,7)=0 → 0. Write to (12,5) → no cell changes.
- Fill row 19 completely and set (4,18); pulse `clear_start` → `clear_done` after 22 cycles, `lines_cleared` = 1, row 19 = 10'b0000010000, row 18 = 0.
- Fill rows 16–19 completely and set (0,15) → `lines_cleared` = 4, `clear_done` at k+25, row 19 = 10'b0000000001, rows 0–18 = 0. With the macro defined, `total_lines` = 4.
- Full rows 17 and 19, row 18 = 10'h155 → row 19 = 10'h155 and `lines_cleared` = 2. A write (0,0) issued and a second `clear_start` pulsed mid-pass are both ignored.
- Assert `reset` during FILL → next cycle all cells 0, `clear_busy` = 0, no `clear_done` pulse.

Source files
------------

// File: rtl/board_store_if.sv
// Board store access bus: cell read/write, renderer row read and
// line-clear control/status. Master drives, slave is the store.
interface board_store_if #(
  parameter int COLS = 10
);
  logic [3:0]      board_rx;
  logic [4:0]      board_ry;
  logic            board_rdata;
  logic            board_we;
  logic [3:0]      board_wx;
  logic [4:0]      board_wy;
  logic            board_wdata;
  logic [4:0]      vga_ry;
  logic [COLS-1:0] vga_row;
  logic            clear_start;
  logic            clear_busy;
  logic            clear_done;
  logic [2:0]      lines_cleared;
  logic [9:0]      total_lines;

  modport master (
    output board_rx, board_ry,
    output board_we, board_wx,
    output board_wy, board_wdata,
    output vga_ry, clear_start,
    input  board_rdata, vga_row,
    input  clear_busy, clear_done,
    input  lines_cleared, total_lines
  );

  modport slave (
    input  board_rx, board_ry,
    input  board_we, board_wx,
    input  board_wy, board_wdata,
    input  vga_ry, clear_start,
    output board_rdata, vga_row,
    output clear_busy, clear_done,
    output lines_cleared, total_lines
  );
endinterface

// File: rtl/board_store.sv
// Playfield occupancy grid with cell/row reads, cell writes and a
// sequential line-clear pass. BOARD_STATS_EN adds a lines total.
module board_store #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input logic          CLOCK_50,
  input logic          reset,
  board_store_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] XMAX = 4'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] rows_d [ROWS];
  logic [1:0]      state_q, state_d;
  logic [4:0]      src_q, src_d;
  logic [4:0]      dst_q, dst_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      lines_q, lines_d;

  logic            rd_ok;
  logic            wr_ok;
  logic            vga_ok;
  logic            src_full;
  logic            src_last;
  logic            dst_last;

  assign rd_ok  = (bus.board_rx <= XMAX) &&
                  (bus.board_ry <= YMAX);
  assign wr_ok  = (bus.board_wx <= XMAX) &&
                  (bus.board_wy <= YMAX);
  assign vga_ok = (bus.vga_ry <= YMAX);

  // Out-of-range cells read as wall
  assign bus.board_rdata = rd_ok ?
    rows_q[bus.board_ry][bus.board_rx] : 1'b1;
  assign bus.vga_row = vga_ok ?
    rows_q[bus.vga_ry] : '0;

  assign src_full = &rows_q[src_q];
  assign src_last = (src_q == 5'd0);
  assign dst_last = (dst_q == 5'd0);

  assign bus.clear_busy    = busy_q;
  assign bus.clear_done    = done_q;
  assign bus.lines_cleared = lines_q;

  // Next-state: cell writes in idle, then scan/fill/done pass
  always_comb begin
    rows_d  = rows_q;
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lines_d = lines_q;
    case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else begin
          if (bus.board_we && wr_ok)
            rows_d[bus.board_wy][bus.board_wx] =
              bus.board_wdata;
          if (bus.clear_start) begin
            state_d = S_SCAN;
            src_d   = YMAX;
            dst_d   = YMAX;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (src_full) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          rows_d[dst_q] = rows_q[src_q];
          dst_d = dst_q - 5'd1;
        end
        src_d = src_q - 5'd1;
        if (src_last)
          state_d = (cnt_d != '0) ? S_FILL : S_DONE;
      end
      S_FILL: begin
        rows_d[dst_q] = '0;
        dst_d = dst_q - 5'd1;
        if (dst_last)
          state_d = S_DONE;
      end
      default: begin
        lines_d = cnt_q[2:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pass state and grid registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rows_q  <= '{default: '0};
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lines_q <= '0;
    end else begin
      rows_q  <= rows_d;
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lines_q <= lines_d;
    end
  end

`ifdef BOARD_STATS_EN
  logic [9:0]  total_q, total_d;
  logic [10:0] total_sum;

  assign total_sum = {1'b0, total_q} +
                     {8'd0, cnt_q[2:0]};

  // Saturating running total, bumped in the done cycle
  always_comb begin
    total_d = total_q;
    if (state_q == S_DONE)
      total_d = total_sum[10] ? 10'h3FF :
                                total_sum[9:0];
  end

  // Total register, cleared only by reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign bus.total_lines = total_q;
`else
  assign bus.total_lines = '0;
`endif

endmodule

// File: tb/tb_board_store.sv
// Scoreboarded bench for board_store: directed line-clear cases
// plus randomized boards against a row-list reference model.
module tb_board_store;

  typedef struct {
    int lines;
    int total;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  bit [9:0] mrow [20];
  int       mtotal = 0;

  board_store_if bif ();

  board_store dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bif)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm,
                     logic [31:0] got,
                     logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, got, want);
    end
  endtask

  // Monitor: every done pulse must match a queued pass
  always @(negedge clk) begin
    if (bif.clear_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=1 exp=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_lines", bif.lines_cleared, e.lines);
        chk("done_total", bif.total_lines, e.total);
        chk("done_cycle", cyc, e.cyc);
        chk("done_busy", bif.clear_busy, 1);
      end
    end
  end

  function automatic int model_clear();
    bit [9:0] keep [$];
    int n = 0;
    for (int y = 19; y >= 0; y--) begin
      if (mrow[y] == 10'h3FF) n++;
      else keep.push_back(mrow[y]);
    end
    for (int y = 19; y >= 0; y--) begin
      if (keep.size() != 0) mrow[y] = keep.pop_front();
      else mrow[y] = '0;
    end
`ifdef BOARD_STATS_EN
    mtotal = (mtotal + n > 1023) ? 1023 : mtotal + n;
`else
    mtotal = 0;
`endif
    return n;
  endfunction

  task automatic wr(int x, int y, bit v);
    @(negedge clk);
    bif.board_we    = 1'b1;
    bif.board_wx    = 4'(x);
    bif.board_wy    = 5'(y);
    bif.board_wdata = v;
    @(posedge clk);
    #1;
    bif.board_we = 1'b0;
    if (x < 10 && y < 20) mrow[y][x] = v;
  endtask

  task automatic set_row(int y, bit [9:0] v);
    for (int x = 0; x < 10; x++) wr(x, y, v[x]);
  endtask

  task automatic rd_chk(int x, int y);
    logic want;
    @(negedge clk);
    bif.board_rx = 4'(x);
    bif.board_ry = 5'(y);
    #1;
    want = (x < 10 && y < 20) ? mrow[y][x] : 1'b1;
    chk($sformatf("rd_%0d_%0d", x, y),
        bif.board_rdata, want);
  endtask

  task automatic check_board(string tag);
    @(negedge clk);
    for (int y = 0; y < 20; y++) begin
      bif.vga_ry = 5'(y);
      #1;
      chk($sformatf("%s_row%0d", tag, y),
          bif.vga_row, mrow[y]);
    end
  endtask

  task automatic run_pass(string tag, bit intrude);
    int   n;
    int   k;
    exp_t e;
    n = model_clear();
    @(negedge clk);
    bif.clear_start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    e.lines = n;
    e.total = mtotal;
    e.cyc   = k + 21 + n;
    exp_q.push_back(e);
    @(negedge clk);
    bif.clear_start = 1'b0;
    chk({tag, "_busy_rise"}, bif.clear_busy, 1);
    if (intrude) begin
      repeat (3) @(negedge clk);
      bif.board_we    = 1'b1;
      bif.board_wx    = 4'd0;
      bif.board_wy    = 5'd0;
      bif.board_wdata = ~mrow[0][0];
      bif.clear_start = 1'b1;
      @(negedge clk);
      bif.board_we    = 1'b0;
      bif.clear_start = 1'b0;
    end
    for (int i = 0; i < 60 && bif.clear_busy; i++)
      @(negedge clk);
    chk({tag, "_busy_fall"}, bif.clear_busy, 0);
    chk({tag, "_lines"}, bif.lines_cleared, n);
    chk({tag, "_total"}, bif.total_lines, mtotal);
    check_board(tag);
  endtask

  initial begin
    int k;
    bif.board_rx    = '0;
    bif.board_ry    = '0;
    bif.board_we    = 1'b0;
    bif.board_wx    = '0;
    bif.board_wy    = '0;
    bif.board_wdata = 1'b0;
    bif.vga_ry      = '0;
    bif.clear_start = 1'b0;
    foreach (mrow[y]) mrow[y] = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bif.clear_busy, 0);
    chk("rst_done", bif.clear_done, 0);
    chk("rst_lines", bif.lines_cleared, 0);
    chk("rst_total", bif.total_lines, 0);
    check_board("rst");
    rd_chk(10, 0);
    rd_chk(0, 20);
    rd_chk(9, 19);
    @(negedge clk);
    bif.vga_ry = 5'd25;
    #1;
    chk("vga_oob", bif.vga_row, 0);

    wr(3, 7, 1'b1);
    rd_chk(3, 7);
    wr(3, 7, 1'b0);
    rd_chk(3, 7);
    wr(12, 5, 1'b1);
    check_board("oobwr");

    set_row(19, 10'h3FF);
    wr(4, 18, 1'b1);
    run_pass("one", 1'b0);

    for (int y = 16; y < 20; y++) set_row(y, 10'h3FF);
    wr(0, 15, 1'b1);
    run_pass("four", 1'b0);

    set_row(17, 10'h3FF);
    set_row(18, 10'h155);
    set_row(19, 10'h3FF);
    run_pass("two", 1'b1);

    set_row(18, 10'h3FF);
    set_row(19, 10'h3FF);
    set_row(10, 10'h0F0);
    @(negedge clk);
    bif.clear_start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    @(negedge clk);
    bif.clear_start = 1'b0;
    while (cyc < k + 20) @(negedge clk);
    chk("fill_busy", bif.clear_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    foreach (mrow[y]) mrow[y] = '0;
    mtotal = 0;
    chk("mid_rst_busy", bif.clear_busy, 0);
    chk("mid_rst_lines", bif.lines_cleared, 0);
    chk("mid_rst_total", bif.total_lines, 0);
    check_board("midrst");
    repeat (30) @(negedge clk);

    for (int p = 0; p < 6; p++) begin
      int quota;
      int nf;
      quota = $urandom_range(0, 4);
      nf = 0;
      for (int y = 0; y < 20; y++) begin
        bit [9:0] pat;
        if (nf < quota && $urandom_range(0, 3) == 0) begin
          pat = 10'h3FF;
          nf++;
        end else begin
          pat = 10'($urandom);
          pat[$urandom_range(0, 9)] = 1'b0;
        end
        set_row(y, pat);
        wr($urandom_range(10, 15),
           $urandom_range(0, 31), 1'b1);
        wr($urandom_range(0, 15),
           $urandom_range(20, 31), 1'b1);
      end
      for (int i = 0; i < 8; i++)
        rd_chk($urandom_range(0, 15),
               $urandom_range(0, 31));
      run_pass($sformatf("rnd%0d", p), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
